// File: rtl/lcd_dcs_sched_if.sv
// Command-path bundle between the DCS scheduler, its two runtime requesters,
// the power sequencer and the DSI command-packet transmitter.
interface lcd_dcs_if;
  logic       hs_start;
  logic       req0, req0_has_param, ack0;
  logic [7:0] req0_cmd, req0_param;
  logic       req1, req1_has_param, ack1;
  logic [7:0] req1_cmd, req1_param;
  logic       tx_valid, tx_ready, tx_has_param, tx_done;
  logic [7:0] tx_cmd, tx_param;
  logic       init_done, busy;

  modport slave (
    input  hs_start,
    input  req0, req0_cmd, req0_param, req0_has_param,
    input  req1, req1_cmd, req1_param, req1_has_param,
    input  tx_ready, tx_done,
    output ack0, ack1, tx_valid, tx_cmd, tx_param, tx_has_param, init_done, busy
  );

  modport master (
    output hs_start,
    output req0, req0_cmd, req0_param, req0_has_param,
    output req1, req1_cmd, req1_param, req1_has_param,
    output tx_ready, tx_done,
    input  ack0, ack1, tx_valid, tx_cmd, tx_param, tx_has_param, init_done, busy
  );
endinterface

// File: rtl/lcd_dcs_sched.sv
// LCD DCS command scheduler: runs the panel bring-up script after hs_start,
// then round-robins the DSI command transmitter between two requesters.
module lcd_dcs_sched #(
  parameter int unsigned TICK_1MS  = 27000,
  parameter int unsigned SLPOUT_MS = 120,
  parameter int unsigned DISPON_MS = 20,
  parameter logic [7:0]  PIXFMT    = 8'h55
) (
  input  logic      clk,
  input  logic      resetn,
  lcd_dcs_if.slave  bus
);

  localparam int unsigned   TW        = (TICK_1MS > 1) ? $clog2(TICK_1MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_1MS - 1);

  typedef enum logic [2:0] {
    ST_WAIT_HS, ST_INIT_ISSUE, ST_INIT_WAIT, ST_INIT_DELAY,
    ST_RUN_IDLE, ST_RUN_ISSUE, ST_RUN_WAIT
  } state_e;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] param;
    logic       has_param;
  } pkt_t;

  function automatic pkt_t scr_pkt(input logic [1:0] s);
    case (s)
      2'd0:    scr_pkt = '{8'h11, 8'h00, 1'b0};
      2'd1:    scr_pkt = '{8'h3A, PIXFMT, 1'b1};
      default: scr_pkt = '{8'h29, 8'h00, 1'b0};
    endcase
  endfunction

  function automatic logic [7:0] scr_dly(input logic [1:0] s);
    case (s)
      2'd0:    scr_dly = 8'(SLPOUT_MS);
      2'd1:    scr_dly = 8'd0;
      default: scr_dly = 8'(DISPON_MS);
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [TW-1:0] tick_q;
  logic [7:0]    ms_q, dly;
  logic          rr_q, rr_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  pkt_t          pkt_q, pkt_d;
  logic          tick_wrap, dly_done;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    rr_d      = rr_q;
    pkt_d     = pkt_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    dly       = scr_dly(step_q);
    tick_wrap = (tick_q == TICK_LAST);
    // Delay ends on the tick that would carry the ms counter up to dly.
    dly_done  = (dly == 8'd0) || (tick_wrap && (ms_q == dly - 8'd1));
    case (state_q)
      ST_WAIT_HS: begin
        step_d = 2'd0;
        if (bus.hs_start) begin
          pkt_d   = scr_pkt(2'd0);
          state_d = ST_INIT_ISSUE;
        end
      end
      ST_INIT_ISSUE: if (bus.tx_ready) state_d = ST_INIT_WAIT;
      ST_INIT_WAIT:  if (bus.tx_done)  state_d = ST_INIT_DELAY;
      ST_INIT_DELAY: begin
        if (dly_done) begin
          if (step_q == 2'd2) begin
            state_d = ST_RUN_IDLE;
          end else begin
            step_d  = step_q + 2'd1;
            pkt_d   = scr_pkt(step_q + 2'd1);
            state_d = ST_INIT_ISSUE;
          end
        end
      end
      ST_RUN_IDLE: begin
        // rr_q holds the last grantee; on a tie the other side wins.
        if (bus.req0 && (!bus.req1 || rr_q)) begin
          rr_d    = 1'b0;
          pkt_d   = '{bus.req0_cmd, bus.req0_param, bus.req0_has_param};
          state_d = ST_RUN_ISSUE;
        end else if (bus.req1) begin
          rr_d    = 1'b1;
          pkt_d   = '{bus.req1_cmd, bus.req1_param, bus.req1_has_param};
          state_d = ST_RUN_ISSUE;
        end
      end
      ST_RUN_ISSUE: if (bus.tx_ready) state_d = ST_RUN_WAIT;
      ST_RUN_WAIT: begin
        if (bus.tx_done) begin
          ack0_d  = !rr_q;
          ack1_d  = rr_q;
          state_d = ST_RUN_IDLE;
        end
      end
      default: state_d = ST_WAIT_HS;
    endcase
    // Losing the HS clock abandons everything, including an in-flight grant.
    if (!bus.hs_start) begin
      state_d = ST_WAIT_HS;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_WAIT_HS;
      step_q  <= 2'd0;
      rr_q    <= 1'b1;
      pkt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      tick_q  <= '0;
      ms_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rr_q    <= rr_d;
      pkt_q   <= pkt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      if (state_d != state_q) begin
        tick_q <= '0;
        ms_q   <= 8'd0;
      end else if (tick_wrap) begin
        tick_q <= '0;
        ms_q   <= ms_q + 8'd1;
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

  assign bus.tx_valid     = (state_q == ST_INIT_ISSUE) || (state_q == ST_RUN_ISSUE);
  assign bus.tx_cmd       = pkt_q.cmd;
  assign bus.tx_param     = pkt_q.param;
  assign bus.tx_has_param = pkt_q.has_param;
  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.init_done    = (state_q == ST_RUN_IDLE) || (state_q == ST_RUN_ISSUE) ||
                            (state_q == ST_RUN_WAIT);
  assign bus.busy         = (state_q != ST_WAIT_HS) && (state_q != ST_RUN_IDLE);

endmodule
